// File: rtl/dram_cmd_issuer.sv
`default_nettype none
// ==========================================================================
// dram_cmd_issuer : open-page DRAM command issuer with periodic refresh
// Revision 1.0
// ==========================================================================
module dram_cmd_issuer #(
  parameter int ADDRWIDTH     = 17,
  parameter int BANKGROUPS    = 2,
  parameter int BANKSPERGROUP = 2,
  parameter int COLS          = 1024,
  parameter int TRCD          = 4,
  parameter int TRP           = 4,
  parameter int TCCD          = 2,
  parameter int TRFC          = 16,
  parameter int TREFI         = 512,
  localparam int BGWIDTH      = $clog2(BANKGROUPS),
  localparam int BAWIDTH      = $clog2(BANKSPERGROUP),
  localparam int CADDRWIDTH   = $clog2(COLS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [BGWIDTH:0]      req_bg,
  input  logic [BAWIDTH:0]      req_ba,
  input  logic [ADDRWIDTH-1:0]  req_row,
  input  logic [CADDRWIDTH-1:0] req_col,
  output logic                  ACT,
  output logic                  PR,
  output logic                  PRA,
  output logic                  RD,
  output logic                  WR,
  output logic                  REF,
  output logic [BGWIDTH:0]      bg,
  output logic [BAWIDTH:0]      ba,
  output logic [ADDRWIDTH-1:0]  row,
  output logic [CADDRWIDTH-1:0] column,
  output logic                  ref_busy
);

  localparam int NBANKS = BANKGROUPS * BANKSPERGROUP;
  localparam int BKW    = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam int TMAX1  = (TRCD > TRP) ? TRCD : TRP;
  localparam int TMAX2  = (TCCD > TRFC) ? TCCD : TRFC;
  localparam int TMAX   = (TMAX1 > TMAX2) ? TMAX1 : TMAX2;
  localparam int CNTW   = $clog2(TMAX + 1);
  localparam int RCW    = (TREFI > 1) ? $clog2(TREFI) : 1;
  localparam int AOW    = BGWIDTH + 1 + BAWIDTH + 1 + ADDRWIDTH + CADDRWIDTH;

  typedef enum logic [3:0] {
    IDLE, DECIDE, WAIT_RP, DO_ACT, WAIT_RCD, DO_RW, WAIT_CCD,
    REF_PRA_WAIT, DO_REF, WAIT_RFC
  } state_t;

  state_t                state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [RCW-1:0]        refcnt_q, refcnt_d;
  logic                  ref_pend_q, ref_pend_d;
  logic [NBANKS-1:0]     open_q, open_d;
  logic [ADDRWIDTH-1:0]  open_row_q [NBANKS];
  logic [ADDRWIDTH-1:0]  open_row_d [NBANKS];
  logic                  wr_q;
  logic [BGWIDTH:0]      bg_q;
  logic [BAWIDTH:0]      ba_q;
  logic [ADDRWIDTH-1:0]  row_q;
  logic [CADDRWIDTH-1:0] col_q;
  logic [AOW-1:0]        addr_q;

  logic                  w_act, w_pr, w_pra, w_rw, w_ref;
  logic                  w_accept;
  logic [BKW-1:0]        w_bank;
  logic                  w_hit;
  logic [AOW-1:0]        w_addr;

  assign w_bank    = BKW'(int'(bg_q) * BANKSPERGROUP + int'(ba_q));
  assign w_hit     = open_q[w_bank] && (open_row_q[w_bank] == row_q);
  assign req_ready = rst & ~halt & (state_q == IDLE) & ~ref_pend_q;
  assign w_accept  = req_valid & req_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    refcnt_d   = refcnt_q;
    ref_pend_d = ref_pend_q;
    open_d     = open_q;
    open_row_d = open_row_q;
    w_act      = 1'b0;
    w_pr       = 1'b0;
    w_pra      = 1'b0;
    w_rw       = 1'b0;
    w_ref      = 1'b0;
    // Everything, including the refresh timer, freezes while halted.
    if (rst && !halt) begin
      unique case (state_q)
        IDLE: begin
          if (ref_pend_q) begin
            if (|open_q) w_pra = 1'b1;
            else         w_ref = 1'b1;
          end else if (req_valid) begin
            state_d = DECIDE;
          end
        end
        DECIDE: begin
          if (!open_q[w_bank]) w_act = 1'b1;
          else if (w_hit)      w_rw  = 1'b1;
          else                 w_pr  = 1'b1;
        end
        WAIT_RP: begin
          cnt_d = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) state_d = DO_ACT;
        end
        WAIT_RCD: begin
          cnt_d = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) state_d = DO_RW;
        end
        WAIT_CCD, WAIT_RFC: begin
          cnt_d = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) state_d = IDLE;
        end
        REF_PRA_WAIT: begin
          cnt_d = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) state_d = DO_REF;
        end
        DO_ACT:  w_act = 1'b1;
        DO_RW:   w_rw  = 1'b1;
        DO_REF:  w_ref = 1'b1;
        default: state_d = IDLE;
      endcase

      // Each issued command arms the wait that guards the next one.
      if (w_pr) begin
        open_d[w_bank] = 1'b0;
        state_d        = (TRP == 1) ? DO_ACT : WAIT_RP;
        cnt_d          = CNTW'(TRP - 1);
      end
      if (w_act) begin
        open_d[w_bank]     = 1'b1;
        open_row_d[w_bank] = row_q;
        state_d            = (TRCD == 1) ? DO_RW : WAIT_RCD;
        cnt_d              = CNTW'(TRCD - 1);
      end
      if (w_rw) begin
        state_d = (TCCD == 1) ? IDLE : WAIT_CCD;
        cnt_d   = CNTW'(TCCD - 1);
      end
      if (w_pra) begin
        state_d = (TRP == 1) ? DO_REF : REF_PRA_WAIT;
        cnt_d   = CNTW'(TRP - 1);
      end
      if (w_ref) begin
        open_d     = '0;
        ref_pend_d = 1'b0;
        for (int i = 0; i < NBANKS; i++) open_row_d[i] = '0;
        state_d    = (TRFC == 1) ? IDLE : WAIT_RFC;
        cnt_d      = CNTW'(TRFC - 1);
      end

      // A fresh expiry overrides a same-cycle clear so it is never lost.
      if (refcnt_q == RCW'(TREFI - 1)) begin
        refcnt_d   = '0;
        ref_pend_d = 1'b1;
      end else begin
        refcnt_d = refcnt_q + RCW'(1);
      end
    end
  end

  always_comb begin
    w_addr = addr_q;
    if (w_act || w_pr || w_rw) w_addr = {bg_q, ba_q, row_q, col_q};
    else if (w_pra || w_ref)   w_addr = '0;
    if (!rst)                  w_addr = '0;
  end

  assign {bg, ba, row, column} = w_addr;
  assign ACT      = w_act;
  assign PR       = w_pr;
  assign PRA      = w_pra;
  assign RD       = w_rw & ~wr_q;
  assign WR       = w_rw & wr_q;
  assign REF      = w_ref;
  assign ref_busy = rst & (ref_pend_q | (state_q == REF_PRA_WAIT) |
                           (state_q == DO_REF) | (state_q == WAIT_RFC));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      refcnt_q   <= '0;
      ref_pend_q <= 1'b0;
      open_q     <= '0;
      for (int i = 0; i < NBANKS; i++) open_row_q[i] <= '0;
      wr_q       <= 1'b0;
      bg_q       <= '0;
      ba_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      refcnt_q   <= refcnt_d;
      ref_pend_q <= ref_pend_d;
      open_q     <= open_d;
      open_row_q <= open_row_d;
      addr_q     <= w_addr;
      if (w_accept) begin
        wr_q  <= req_write;
        bg_q  <= req_bg;
        ba_q  <= req_ba;
        row_q <= req_row;
        col_q <= req_col;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dram_cmd_issuer.sv
`default_nettype none
// ==========================================================================
// tb_dram_cmd_issuer : randomized bench against a command-schedule model
// Revision 1.0
// ==========================================================================
module tb_dram_cmd_issuer;

  localparam int AW    = 17;
  localparam int CW    = 10;
  localparam int BPG   = 2;
  localparam int TRCD  = 4;
  localparam int TRP   = 4;
  localparam int TCCD  = 2;
  localparam int TRFC  = 16;
  localparam int TREFI = 512;

  localparam logic [5:0] C_ACT = 6'b100000;
  localparam logic [5:0] C_PR  = 6'b010000;
  localparam logic [5:0] C_PRA = 6'b001000;
  localparam logic [5:0] C_RD  = 6'b000100;
  localparam logic [5:0] C_WR  = 6'b000010;
  localparam logic [5:0] C_REF = 6'b000001;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          halt = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [1:0]    req_bg = '0;
  logic [1:0]    req_ba = '0;
  logic [AW-1:0] req_row = '0;
  logic [CW-1:0] req_col = '0;
  logic          req_ready, ACT, PR, PRA, RD, WR, REF, ref_busy;
  logic [1:0]    bg, ba;
  logic [AW-1:0] row;
  logic [CW-1:0] column;

  always #5 clk = ~clk;

  dram_cmd_issuer dut (
    .clk(clk), .rst(rst), .halt(halt),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .ACT(ACT), .PR(PR), .PRA(PRA), .RD(RD), .WR(WR), .REF(REF),
    .bg(bg), .ba(ba), .row(row), .column(column), .ref_busy(ref_busy)
  );

  int n_vec    = 0;
  int n_miscmp = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Model state, counted in non-halted cycles since the last reset.
  int          j, busy_until, ref_until;
  bit          pend;
  bit          open_v [4];
  logic [AW-1:0] open_r [4];
  logic [5:0]  sched_cmd  [int];
  logic [30:0] sched_addr [int];
  logic [30:0] last_addr;

  task automatic model_reset();
    j = 0; busy_until = 0; ref_until = 0; pend = 1'b0; last_addr = '0;
    for (int k = 0; k < 4; k++) begin open_v[k] = 1'b0; open_r[k] = '0; end
    sched_cmd.delete();
    sched_addr.delete();
  endtask

  task automatic put(input int t, input logic [5:0] c, input logic [30:0] a);
    sched_cmd[t]  = c;
    sched_addr[t] = a;
  endtask

  task automatic step(input bit r, input bit h, input bit v, input bit w,
                      input logic [1:0] b_g, input logic [1:0] b_a,
                      input logic [AW-1:0] rw, input logic [CW-1:0] cl);
    logic [5:0]  ecmd;
    logic [30:0] eaddr, a;
    bit          erdy, any;
    int          bank, t;
    @(posedge clk);
    #1;
    rst = r; halt = h; req_valid = v; req_write = w;
    req_bg = b_g; req_ba = b_a; req_row = rw; req_col = cl;
    @(negedge clk);
    if (!r) begin
      check_eq("cmd_rst",   {ACT, PR, PRA, RD, WR, REF}, 0);
      check_eq("ready_rst", req_ready, 0);
      check_eq("busy_rst",  ref_busy, 0);
      check_eq("addr_rst",  {bg, ba, row, column}, 0);
      model_reset();
    end else if (h) begin
      check_eq("cmd_halt",   {ACT, PR, PRA, RD, WR, REF}, 0);
      check_eq("ready_halt", req_ready, 0);
      check_eq("busy_halt",  ref_busy, 64'(pend || (j < ref_until)));
      check_eq("addr_halt",  {bg, ba, row, column}, last_addr);
    end else begin
      erdy = 1'b0;
      a    = {b_g, b_a, rw, cl};
      if (j >= busy_until) begin
        if (pend) begin
          any = 1'b0;
          for (int k = 0; k < 4; k++) any |= open_v[k];
          if (any) begin
            put(j, C_PRA, '0);
            put(j + TRP, C_REF, '0);
            busy_until = j + TRP + TRFC;
          end else begin
            put(j, C_REF, '0);
            busy_until = j + TRFC;
          end
          ref_until = busy_until;
          for (int k = 0; k < 4; k++) open_v[k] = 1'b0;
        end else begin
          erdy = 1'b1;
          if (v) begin
            bank = int'(b_g) * BPG + int'(b_a);
            t    = j + 1;
            if (open_v[bank] && open_r[bank] != rw) begin
              put(t, C_PR, a); t += TRP;
              put(t, C_ACT, a); t += TRCD;
            end else if (!open_v[bank]) begin
              put(t, C_ACT, a); t += TRCD;
            end
            put(t, w ? C_WR : C_RD, a);
            busy_until   = t + TCCD;
            open_v[bank] = 1'b1;
            open_r[bank] = rw;
          end
        end
      end
      ecmd  = sched_cmd.exists(j) ? sched_cmd[j] : 6'b0;
      eaddr = (ecmd == 6'b0) ? last_addr : sched_addr[j];
      check_eq("cmd",   {ACT, PR, PRA, RD, WR, REF}, ecmd);
      check_eq("ready", req_ready, erdy);
      check_eq("busy",  ref_busy, 64'(pend || (j < ref_until)));
      check_eq("addr",  {bg, ba, row, column}, eaddr);
      if (ecmd == C_REF) pend = 1'b0;
      last_addr = eaddr;
      j++;
      if (j % TREFI == 0) pend = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    // Closed-bank read, then a page hit, then a row conflict write.
    step(1, 0, 1, 0, 2'd0, 2'd1, 17'd5, 10'd8); idle(8);
    step(1, 0, 1, 0, 2'd0, 2'd1, 17'd5, 10'd9); idle(4);
    step(1, 0, 1, 1, 2'd0, 2'd1, 17'd7, 10'd3); idle(12);
    // Long idle with a bank open forces PRA then REF.
    idle(520);
    // Halt inside the ACT-to-RD window.
    step(1, 0, 1, 0, 2'd1, 2'd0, 17'd2, 10'd7); idle(2);
    repeat (3) step(1, 1, 0, 0, 0, 0, 0, 0);
    idle(8);
    // Reset while waiting out tRP; the bank must come back closed.
    step(1, 0, 1, 0, 2'd0, 2'd0, 17'd1, 10'd1); idle(8);
    step(1, 0, 1, 0, 2'd0, 2'd0, 17'd4, 10'd2); idle(2);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 2'd0, 2'd0, 17'd4, 10'd2); idle(10);
    // Randomized traffic with halts and rare resets.
    for (int n = 0; n < 4000; n++) begin
      step(($urandom % 1000) != 0, ($urandom % 10) == 0, $urandom % 2, $urandom % 2,
           2'($urandom % 2), 2'($urandom % 2), AW'($urandom % 4), CW'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
`default_nettype wire
